// File: rtl/mult_iter_counter_pkg.sv
// Shared encodings and defaults for the shift-add multiplier iteration counter and control FSM.
// No logic here: types and constants only, no latency or backpressure involved.
package mult_iter_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH     = 5;
  localparam int MULT_N_DEFAULT = 8;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the shift-add multiplier: K/KPulse from edge Load+Len_r with En held high.
// All outputs registered; En acts as the only throttle (no backpressure), Rst > Load > En.
module mult_iter_counter
  import mult_iter_counter_pkg::*;
#(
  parameter int WIDTH     = MULT_WIDTH,
  parameter int N_DEFAULT = MULT_N_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic             En,
  input  logic [WIDTH-1:0] LenIn,
  input  logic             AutoRld,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             K,
  output logic             KPulse
);

  localparam logic [WIDTH-1:0] N_DEF = WIDTH'(N_DEFAULT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             k_q, k_d;
  logic             kpulse_q, kpulse_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    k_d      = k_q;
    kpulse_d = 1'b0;

    if (Load) begin
      // Restart from any state; an aborted run never produces a pulse.
      len_d   = (LenIn == '0) ? N_DEF : LenIn;
      count_d = '0;
      k_d     = 1'b0;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          if (En) begin
            if (count_q == (len_q - WIDTH'(1))) begin
              kpulse_d = 1'b1;
              if (AutoRld) begin
                count_d = '0;
              end else begin
                count_d = len_q;
                k_d     = 1'b1;
                state_d = S_DONE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      len_q    <= N_DEF;
      k_q      <= 1'b0;
      kpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      k_q      <= k_d;
      kpulse_q <= kpulse_d;
    end
  end

  assign Count  = count_q;
  assign Busy   = (state_q == S_RUN);
  assign K      = k_q;
  assign KPulse = kpulse_q;

endmodule

// File: tb/tb_mult_iter_counter.sv
// Directed bench for mult_iter_counter: one table of per-edge vectors plus hand-written long sequences.
module tb_mult_iter_counter;

  logic       Clk = 1'b0;
  logic       Rst, Load, En, AutoRld;
  logic [4:0] LenIn;
  logic [4:0] Count;
  logic       Busy, K, KPulse;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mult_iter_counter #(.WIDTH(5), .N_DEFAULT(8)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Load   (Load),
    .En     (En),
    .LenIn  (LenIn),
    .AutoRld(AutoRld),
    .Count  (Count),
    .Busy   (Busy),
    .K      (K),
    .KPulse (KPulse)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       load;
    logic       en;
    logic [4:0] len;
    logic       ar;
    logic [4:0] cnt;
    logic       busy;
    logic       k;
    logic       kp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rst, input logic load, input logic en,
                     input logic [4:0] len, input logic ar, input logic [4:0] cnt,
                     input logic busy, input logic k, input logic kp);
    vec_t v;
    v.name = nm; v.rst = rst; v.load = load; v.en = en; v.len = len; v.ar = ar;
    v.cnt = cnt; v.busy = busy; v.k = k; v.kp = kp;
    vecs.push_back(v);
  endtask

  // Apply inputs for one rising edge, then let outputs settle before sampling.
  task automatic drive(input logic rst, input logic load, input logic en,
                       input logic [4:0] len, input logic ar);
    Rst = rst; Load = load; En = en; LenIn = len; AutoRld = ar;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic [4:0] cnt,
                       input logic busy, input logic k, input logic kp);
    checks++;
    if (Count !== cnt) begin
      errors++;
      $display("FAIL %s[%0d] Count: got %0d expected %0d", nm, idx, Count, cnt);
    end
    checks++;
    if (Busy !== busy) begin
      errors++;
      $display("FAIL %s[%0d] Busy: got %b expected %b", nm, idx, Busy, busy);
    end
    checks++;
    if (K !== k) begin
      errors++;
      $display("FAIL %s[%0d] K: got %b expected %b", nm, idx, K, k);
    end
    checks++;
    if (KPulse !== kp) begin
      errors++;
      $display("FAIL %s[%0d] KPulse: got %b expected %b", nm, idx, KPulse, kp);
    end
  endtask

  initial begin
    Rst = 1'b1; Load = 1'b0; En = 1'b0; LenIn = 5'd0; AutoRld = 1'b0;

    // Reset wins over Load/En; IDLE ignores En.
    add("reset",  1, 1, 1, 5'd3, 0, 5'd0, 0, 0, 0);
    add("reset",  1, 1, 1, 5'd3, 0, 5'd0, 0, 0, 0);
    add("idle_en",0, 0, 1, 5'd3, 0, 5'd0, 0, 0, 0);

    // LenIn=0 selects the default length of 8.
    add("dflt_load", 0, 1, 0, 5'd0, 0, 5'd0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) add("dflt_run", 0, 0, 1, 5'd0, 0, 5'(i), 1, 0, 0);
    add("dflt_term", 0, 0, 1, 5'd0, 0, 5'd8, 0, 1, 1);
    for (int i = 0; i < 5; i++) add("dflt_hold", 0, 0, 1, 5'd0, 0, 5'd8, 0, 1, 0);

    // Length 5 with En toggling; reload from DONE clears K.
    add("tog_load", 0, 1, 0, 5'd5, 0, 5'd0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      add("tog_en",   0, 0, 1, 5'd5, 0, 5'(i), 1, 0, 0);
      add("tog_stall",0, 0, 0, 5'd5, 0, 5'(i), 1, 0, 0);
    end
    add("tog_term", 0, 0, 1, 5'd5, 0, 5'd5, 0, 1, 1);
    add("tog_hold", 0, 0, 0, 5'd5, 0, 5'd5, 0, 1, 0);

    // Auto-reload, length 3: pulse every third edge, K never set.
    add("ar_load", 0, 1, 0, 5'd3, 1, 5'd0, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      add("ar_run", 0, 0, 1, 5'd3, 1, 5'd1, 1, 0, 0);
      add("ar_run", 0, 0, 1, 5'd3, 1, 5'd2, 1, 0, 0);
      add("ar_wrap",0, 0, 1, 5'd3, 1, 5'd0, 1, 0, 1);
    end
    add("ar_idle", 0, 0, 0, 5'd3, 0, 5'd0, 1, 0, 0);

    // Mid-run reload with En also high: Load wins, no pulse, new length 2.
    add("re_load", 0, 1, 0, 5'd6, 0, 5'd0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) add("re_run", 0, 0, 1, 5'd6, 0, 5'(i), 1, 0, 0);
    add("re_abort", 0, 1, 1, 5'd2, 0, 5'd0, 1, 0, 0);
    add("re_run",   0, 0, 1, 5'd2, 0, 5'd1, 1, 0, 0);
    add("re_term",  0, 0, 1, 5'd2, 0, 5'd2, 0, 1, 1);

    // Reset together with Load mid-run, then length 1.
    add("rst_load", 0, 1, 0, 5'd6, 0, 5'd0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) add("rst_run", 0, 0, 1, 5'd6, 0, 5'(i), 1, 0, 0);
    add("rst_mid",  1, 1, 1, 5'd6, 0, 5'd0, 0, 0, 0);
    add("len1_load",0, 1, 0, 5'd1, 0, 5'd0, 1, 0, 0);
    add("len1_term",0, 0, 1, 5'd1, 0, 5'd1, 0, 1, 1);
    add("len1_hold",0, 0, 1, 5'd1, 0, 5'd1, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].len, vecs[i].ar);
      check(vecs[i].name, i, vecs[i].cnt, vecs[i].busy, vecs[i].k, vecs[i].kp);
    end

    // Maximum length 31 with En held high from the Load cycle.
    drive(0, 1, 1, 5'd31, 0);
    check("max_load", 0, 5'd0, 1, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      drive(0, 0, 1, 5'd31, 0);
      check("max_run", i, 5'(i), 1, 0, 0);
    end
    drive(0, 0, 1, 5'd31, 0);
    check("max_term", 31, 5'd31, 0, 1, 1);

    // Length 1 with auto-reload: a pulse on every enabled edge.
    drive(0, 1, 0, 5'd1, 1);
    check("ar1_load", 0, 5'd0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 1, 5'd1, 1);
      check("ar1_wrap", i, 5'd0, 1, 0, 1);
    end
    drive(0, 0, 0, 5'd1, 1);
    check("ar1_stall", 4, 5'd0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
